project1: RTL and testbench
===========================

Name: project1

Overview:
- Four-entry, 4-bit pattern store with timed playback; a small sequencer block.
- Software-style loading: partA (one-hot select) plus partB (data), written while the partC strobe is high.
- A rising edge on partD starts playback of entries 0..3 on partE, each held for HOLD_CYCLES clocks, then partE returns to 0.

Parameters:
- HOLD_CYCLES, 50, clocks each entry is driven on partE during playback (legal range 1..65535).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- partA  input  4  entry select; bit i enables write of entry i.
- partB  input  4  write data.
- partC  input  1  write strobe, level-sensitive, active-high.
- partD  input  1  playback start; rising-edge detected.
- partE  output  4  playback output, registered.

Behaviour:
- One clock domain. Reset is asynchronous and active-low: rst_n low immediately clears all state.
- Reset values:
  - mem[0..3] = 0
  - partE = 0
  - state = IDLE
  - hold counter = 0
  - entry index = 0
  - partD_q (previous partD sample) = 0
- Write, IDLE only:
  - On each clk edge with partC=1, every entry i with partA[i]=1 loads partB.
  - partA=0 writes nothing.
  - Multiple set bits write all selected entries with the same data.
  - Holding partC high for several cycles simply rewrites the same value.
  - Writes while in PLAY are ignored and do not modify mem.
- Start detect:
  - partD_q <= partD every cycle.
  - start = partD & ~partD_q.
  - Holding partD high produces one start only.
- FSM state IDLE:
  - partE holds 0.
  - On start: state <= PLAY, index <= 0, counter <= 0, partE <= mem[0] at that same edge (1-cycle latency from partD sampled high).
- FSM state PLAY:
  - Each cycle counter increments.
  - When counter reaches HOLD_CYCLES-1: counter <= 0.
    - If index < 3: index <= index+1 and partE <= mem[index+1].
    - If index = 3: partE <= 0 and state <= IDLE.
  - Each entry is visible for exactly HOLD_CYCLES clocks; the total playback is 4*HOLD_CYCLES clocks.
  - partE shows the mem value captured at the moment each entry is loaded. Writes are blocked in PLAY, so mem is constant during playback.
  - A start edge during PLAY is ignored and does not restart playback.
- Reset asserted mid-playback: immediate return to IDLE, partE=0, mem cleared.
- Write and start on the same edge in IDLE:
  - The write is performed first.
  - partE shows the newly written value if entry 0 was written on that edge (write data is forwarded for entry 0).

Optional Feature:
- Macro: PROJECT1_LOOP_EN.
- Defined:
  - After entry 3's hold expires, playback wraps to entry 0 (partE <= mem[0]) and continues indefinitely.
  - A subsequent start edge during PLAY stops playback: partE <= 0, state <= IDLE.
  - Writes remain blocked while playing.
- Undefined: single-pass playback exactly as in Behaviour; start edges during PLAY are ignored.

Test Plan:
- Reset: drive rst_n low asynchronously between clock edges -> partE=0 immediately; playback after release outputs 0,0,0,0.
- Load and play:
  - Stimulus: writes (partA,partB) = (0001,1010), (0010,0101), (0100,1110), (1000,0110), each with partC high for 5 cycles; then a partD pulse.
  - Required: partE = A for 50 cycles, 5 for 50, E for 50, 6 for 50, then 0 and IDLE.
- Write mask: partA=0000, partB=F, partC=1 -> mem unchanged. Then partA=0101, partB=3 -> entries 0 and 2 = 3; playback 3,0,3,0 (from reset state).
- Write during PLAY: partA=0001, partB=F, partC=1 mid-playback -> ignored; a later playback still shows the original entry 0.
- Start robustness:
  - partD held high 100 cycles -> single pass only.
  - A second partD edge at cycle 60 of playback -> no restart (loop build: playback stops, partE=0).
- Reset mid-playback at cycle 120: rst_n pulsed low -> partE=0 immediately, state IDLE; a new start plays 0,0,0,0.

Source files
------------

// File: rtl/project1.sv
// -----------------------------------------------------------------------------
// project1 -- four-entry pattern store with timed playback.
//
// Software loads entries by raising the write strobe with a one-hot-style
// entry select and a data nibble. A rising edge on the start input plays
// entries 0..3 on the output. Each entry is held for HOLD_CYCLES clocks, and
// the output then returns to 0.
//
// Ports:
//   clk    in   1       system clock, rising edge
//   rst_n  in   1       asynchronous active-low reset (clears all state)
//   partA  in   4       entry select, bit i enables write of entry i
//   partB  in   DATA_W  write data
//   partC  in   1       write strobe, level-sensitive, active-high
//   partD  in   1       playback start, rising-edge detected
//   partE  out  DATA_W  registered playback output
//
// Parameters:
//   HOLD_CYCLES  clocks each entry is shown during playback (1..65535)
//   DATA_W       entry width
//
// Optional build macro: PROJECT1_LOOP_EN
//   When defined, playback wraps from entry 3 back to entry 0 and runs until
//   another start edge stops it. When undefined, playback makes a single pass
//   and start edges during playback are ignored.
// -----------------------------------------------------------------------------
module project1 #(
  parameter int HOLD_CYCLES = 50,
  parameter int DATA_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        partA,
  input  logic [DATA_W-1:0] partB,
  input  logic              partC,
  input  logic              partD,
  output logic [DATA_W-1:0] partE
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t            state, stateNext;
  logic [CNT_W-1:0]  holdCnt, holdCntNext;
  logic [1:0]        idx, idxNext;
  logic [DATA_W-1:0] outNext;
  logic [DATA_W-1:0] mem [4];
  logic [DATA_W-1:0] memNext [4];
  logic              partDQ;
  logic              start;
  logic [1:0]        idxInc;

  assign start  = partD & ~partDQ;
  assign idxInc = idx + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      holdCnt <= '0;
      idx     <= '0;
      partE   <= '0;
      partDQ  <= 1'b0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      state   <= stateNext;
      holdCnt <= holdCntNext;
      idx     <= idxNext;
      partE   <= outNext;
      partDQ  <= partD;
      for (int i = 0; i < 4; i++) mem[i] <= memNext[i];
    end
  end

  always_comb begin
    stateNext   = state;
    holdCntNext = holdCnt;
    idxNext     = idx;
    outNext     = partE;
    for (int i = 0; i < 4; i++) memNext[i] = mem[i];

    case (state)
      IDLE: begin
        outNext = '0;
        // Writes are only accepted while idle, so mem is frozen during playback.
        if (partC) begin
          for (int i = 0; i < 4; i++)
            if (partA[i]) memNext[i] = partB;
        end
        if (start) begin
          stateNext   = PLAY;
          idxNext     = 2'd0;
          holdCntNext = '0;
          // Use the post-write value so a same-edge write to entry 0 is shown.
          outNext     = memNext[0];
        end
      end

      PLAY: begin
`ifdef PROJECT1_LOOP_EN
        if (start) begin
          stateNext   = IDLE;
          idxNext     = 2'd0;
          holdCntNext = '0;
          outNext     = '0;
        end else
`endif
        if (holdCnt == LAST_CNT) begin
          holdCntNext = '0;
          if (idx != 2'd3) begin
            idxNext = idxInc;
            outNext = mem[idxInc];
          end else begin
`ifdef PROJECT1_LOOP_EN
            idxNext = 2'd0;
            outNext = mem[0];
`else
            idxNext   = 2'd0;
            outNext   = '0;
            stateNext = IDLE;
`endif
          end
        end else begin
          holdCntNext = holdCnt + 16'd1;
        end
      end

      default: begin
        stateNext = IDLE;
        outNext   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_project1.sv
// -----------------------------------------------------------------------------
// tb_project1 -- directed, table-driven bench for project1 (default build).
// -----------------------------------------------------------------------------
module tb_project1;

  localparam int HOLD = 50;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] partA, partB, partE;
  logic       partC, partD;

  int errors = 0;
  int checks = 0;

  project1 #(.HOLD_CYCLES(HOLD), .DATA_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .partA(partA),
    .partB(partB),
    .partC(partC),
    .partD(partD),
    .partE(partE)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        doReset;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        c;
    logic [15:0] expPlay;  // nibble i = expected entry i
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic doWrite(input logic [3:0] a, input logic [3:0] b, input logic c);
    partA = a;
    partB = b;
    partC = c;
    repeat (5) tick();
    partC = 1'b0;
    partA = 4'h0;
    partB = 4'h0;
  endtask

  // Starts playback and checks every cycle of it. holdD: cycles partD stays
  // high; wrAt: cycle at which a 5-cycle write of F to entry 0 begins (-1 none);
  // edge2At: cycle at which a second start pulse is raised (-1 none).
  task automatic playCheck(input logic [15:0] exp, input string name,
                           input int holdD, input int wrAt, input int edge2At);
    logic       bad [4];
    logic [3:0] gotV [4];
    logic [3:0] e;
    for (int i = 0; i < 4; i++) begin bad[i] = 1'b0; gotV[i] = 4'h0; end
    partD = 1'b1;
    tick();
    for (int n = 0; n < 4 * HOLD; n++) begin
      e = exp[4 * (n / HOLD) +: 4];
      if (partE !== e && !bad[n / HOLD]) begin
        bad[n / HOLD]  = 1'b1;
        gotV[n / HOLD] = partE;
      end
      partD = (n + 1 < holdD) || (n == edge2At);
      if (wrAt >= 0 && n >= wrAt && n < wrAt + 5) begin
        partC = 1'b1; partA = 4'b0001; partB = 4'hF;
      end else begin
        partC = 1'b0; partA = 4'h0; partB = 4'h0;
      end
      tick();
    end
    partD = 1'b0;
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s entry%0d", name, i), bad[i] ? gotV[i] : exp[4*i +: 4], exp[4*i +: 4]);
    chk({name, " end"}, partE, 4'h0);
    repeat (3) tick();
    chk({name, " idle"}, partE, 4'h0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 4'b0001, 4'hA, 1'b1, 16'h000A};
    vecs[1] = '{1'b0, 4'b0010, 4'h5, 1'b1, 16'h005A};
    vecs[2] = '{1'b0, 4'b0100, 4'hE, 1'b1, 16'h0E5A};
    vecs[3] = '{1'b0, 4'b1000, 4'h6, 1'b1, 16'h6E5A};
    vecs[4] = '{1'b0, 4'b0000, 4'hF, 1'b1, 16'h6E5A};  // empty select
    vecs[5] = '{1'b0, 4'b1111, 4'h9, 1'b0, 16'h6E5A};  // strobe low
    vecs[6] = '{1'b1, 4'b0101, 4'h3, 1'b1, 16'h0303};  // from reset state
    vecs[7] = '{1'b0, 4'b1010, 4'hC, 1'b1, 16'hC3C3};

    partA = 4'h0; partB = 4'h0; partC = 1'b0; partD = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset partE", partE, 4'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    playCheck(16'h0000, "play after reset", 1, -1, -1);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].doReset) begin
        #2 rst_n = 1'b0;
        #1 chk($sformatf("vec%0d reset", v), partE, 4'h0);
        tick();
        rst_n = 1'b1;
        tick();
      end
      doWrite(vecs[v].a, vecs[v].b, vecs[v].c);
      playCheck(vecs[v].expPlay, $sformatf("vec%0d", v), 1, -1, -1);
    end

    // Write during playback is ignored, later playback unchanged.
    playCheck(16'hC3C3, "wr in play", 1, 60, -1);
    playCheck(16'hC3C3, "after wr in play", 1, -1, -1);

    // partD held high for 100 cycles: one pass only.
    playCheck(16'hC3C3, "held start", 100, -1, -1);

    // Second start edge at cycle 60 does not restart.
    playCheck(16'hC3C3, "second edge", 1, -1, 60);

    // Write to entry 0 on the same edge as start: forwarded to partE.
    partA = 4'b0001; partB = 4'h7; partC = 1'b1; partD = 1'b1;
    tick();
    partC = 1'b0; partA = 4'h0; partB = 4'h0; partD = 1'b0;
    chk("forward entry0", partE, 4'h7);
    repeat (4 * HOLD + 4) tick();
    chk("forward end", partE, 4'h0);
    playCheck(16'hC3C7, "after forward", 1, -1, -1);

    // Reset mid-playback at cycle 120.
    partD = 1'b1;
    tick();
    partD = 1'b0;
    repeat (120) tick();
    chk("mid cycle120", partE, 4'h3);
    #2 rst_n = 1'b0;
    #1 chk("mid reset partE", partE, 4'h0);
    tick();
    chk("mid reset held", partE, 4'h0);
    rst_n = 1'b1;
    tick();
    playCheck(16'h0000, "after mid reset", 1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
